// File: rtl/sw_pkg.sv
// -----------------------------------------------------------------------------
// sw_pkg
// Shared definitions for the switch debouncer front end.
//   sw_state_e  : qualification FSM state (STABLE / CHECK)
//   SYNC_DEPTH  : number of flops in the SW_RAW synchroniser
//   CNT_W       : width of the qualification counter
// -----------------------------------------------------------------------------
package sw_pkg;

  typedef enum logic {
    STABLE = 1'b0,
    CHECK  = 1'b1
  } sw_state_e;

  localparam int SYNC_DEPTH = 2;
  localparam int CNT_W      = 4;

endpackage : sw_pkg

// File: rtl/sw_tick_gen.sv
// -----------------------------------------------------------------------------
// sw_tick_gen
// Free-running prescaler producing a one-cycle sample strobe every DIV clocks.
// Shared by the slow-sampled front-panel inputs, so it never restarts on
// input activity.
//
// Parameters
//   DIV      : clock cycles per tick, 2..65535
// Ports
//   CLK      in  system clock
//   RESET_B  in  asynchronous active-low reset
//   TICK     out high in the cycle the counter equals DIV-1
// -----------------------------------------------------------------------------
module sw_tick_gen #(
  parameter int DIV = 1000
) (
  input  logic CLK,
  input  logic RESET_B,
  output logic TICK
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] count_q;
  logic [CW-1:0] count_d;
  logic          tick;

  // The wrap to 0 happens on the same edge that consumes the tick, so the
  // period is exactly DIV cycles and the first tick lands in cycle DIV.
  always_comb begin
    tick    = (count_q == LAST);
    count_d = tick ? '0 : (count_q + CW'(1));
  end

  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign TICK = tick;

endmodule : sw_tick_gen

// File: rtl/sw_debounce.sv
// -----------------------------------------------------------------------------
// sw_debounce
// Debounces a raw mechanical switch. SW_RAW is synchronised to CLK, sampled
// only on the prescaler tick, and a new level is committed once NSTABLE
// consecutive ticks disagree with the current SW_OUT.
//
// Parameters
//   DIV       : clock cycles per sample tick, 2..65535
//   NSTABLE   : consecutive disagreeing samples needed to commit, 1..15
// Ports
//   CLK       in  system clock
//   RESET_B   in  asynchronous active-low reset
//   SW_RAW    in  raw switch level, asynchronous, may bounce
//   SW_OUT    out debounced level (registered)
//   RISE      out one-cycle pulse, same cycle SW_OUT becomes 1 (registered)
//   FALL      out one-cycle pulse, same cycle SW_OUT becomes 0 (registered)
//   BUSY      out high while a candidate change is qualified (registered)
//   DBG_STATE out current FSM state, for observation only
//   DBG_CNT   out current qualification count, for observation only
//
// Handshake: none. SW_RAW is a level input with no valid/ready; the outputs
// are plain registered levels and pulses with no back-pressure.
// -----------------------------------------------------------------------------
module sw_debounce
  import sw_pkg::*;
#(
  parameter int DIV     = 1000,
  parameter int NSTABLE = 4
) (
  input  logic             CLK,
  input  logic             RESET_B,
  input  logic             SW_RAW,
  output logic             SW_OUT,
  output logic             RISE,
  output logic             FALL,
  output logic             BUSY,
  output sw_state_e        DBG_STATE,
  output logic [CNT_W-1:0] DBG_CNT
);

  localparam logic [CNT_W-1:0] NSTAB = CNT_W'(NSTABLE);

  logic tick;

  sw_tick_gen #(
    .DIV (DIV)
  ) u_tick_gen (
    .CLK     (CLK),
    .RESET_B (RESET_B),
    .TICK    (tick)
  );

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [SYNC_DEPTH-1:0] sync_q, sync_d;
  sw_state_e             state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic                  out_q, out_d;
  logic                  rise_q, rise_d;
  logic                  fall_q, fall_d;
  logic                  busy_q, busy_d;

  logic             sync;
  logic [CNT_W-1:0] cnt_inc;
  logic             commit;

  // ---------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // Synchroniser shifts SW_RAW in at the LSB; the MSB is the only copy
    // the rest of the design looks at.
    sync_d  = {sync_q[SYNC_DEPTH-2:0], SW_RAW};
    sync    = sync_q[SYNC_DEPTH-1];

    state_d = state_q;
    cnt_d   = cnt_q;
    out_d   = out_q;
    commit  = 1'b0;
    cnt_inc = cnt_q + CNT_W'(1);

    // SYNC is only looked at on ticks; between ticks nothing moves.
    if (tick) begin
      case (state_q)
        STABLE: begin
          if (sync != out_q) begin
            if (NSTABLE == 1) begin
              commit = 1'b1;
            end else begin
              state_d = CHECK;
              cnt_d   = CNT_W'(1);
            end
          end
        end
        CHECK: begin
          if (sync == out_q) begin
            // Input went back to the committed level: treat as a bounce.
            state_d = STABLE;
            cnt_d   = '0;
          end else if (cnt_inc >= NSTAB) begin
            commit = 1'b1;
          end else begin
            cnt_d = cnt_inc;
          end
        end
        default: begin
          state_d = STABLE;
          cnt_d   = '0;
        end
      endcase
    end

    if (commit) begin
      out_d   = sync;
      state_d = STABLE;
      cnt_d   = '0;
    end

    // Edge pulses are one cycle wide by construction: they default low and
    // only a commit raises them, and a commit cannot happen two ticks apart
    // in adjacent cycles.
    rise_d = commit &  sync;
    fall_d = commit & ~sync;
    busy_d = (state_d == CHECK);
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge CLK or negedge RESET_B) begin
    if (!RESET_B) begin
      sync_q  <= '0;
      state_q <= STABLE;
      cnt_q   <= '0;
      out_q   <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      sync_q  <= sync_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign SW_OUT    = out_q;
  assign RISE      = rise_q;
  assign FALL      = fall_q;
  assign BUSY      = busy_q;
  assign DBG_STATE = state_q;
  assign DBG_CNT   = cnt_q;

endmodule : sw_debounce
